// File: rtl/cam_pixel_assembler.sv
// OV7670 capture stage: registers the camera bus, pairs bytes into RGB565
// words tagged with frame_start, and checks frame geometry and FIFO overflow.
module cam_pixel_assembler #(
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        v_sync,
   input  logic        h_ref,
   input  logic [7:0]  cam_data,
   input  logic        queue_full,
   output logic [16:0] queue_data,
   output logic        queue_wr_en,
   output logic        frame_done,
   output logic        frame_error,
   output logic        overflow
);

   typedef enum logic [1:0] {
      WAIT_VSYNC = 2'd0,
      FRAME      = 2'd1,
      DROP       = 2'd2
   } state_t;

   localparam logic [9:0] WIDTH_C  = 10'(FRAME_WIDTH);
   localparam logic [8:0] HEIGHT_C = 9'(FRAME_HEIGHT);

   // S0 input stage plus one cycle of history for edge detection
   logic       vs_q, hr_q, vs_p_q, hr_p_q;
   logic [7:0] dat_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_q   <= 1'b0;
         hr_q   <= 1'b0;
         vs_p_q <= 1'b0;
         hr_p_q <= 1'b0;
         dat_q  <= '0;
      end else begin
         vs_q   <= v_sync;
         hr_q   <= h_ref;
         dat_q  <= cam_data;
         vs_p_q <= vs_q;
         hr_p_q <= hr_q;
      end
   end

   state_t      state_q;
   logic [9:0]  col_q;
   logic [8:0]  line_q;
   logic        phase_q, bad_q, arm_q;
   logic [7:0]  hi_q;
   logic        pix_vld_q, fs_q;
   logic [15:0] pix_q;
   logic        done_q, err_q, ovf_q;

   logic       vs_rise, vs_fall, hr_fall;
   logic [9:0] col_d;
   logic [8:0] line_d;
   logic       line_bad, wr_en, drop, pix_ok, frame_bad;

   assign vs_rise = vs_q & ~vs_p_q;
   assign vs_fall = ~vs_q & vs_p_q;
   assign hr_fall = ~hr_q & hr_p_q;

   // Saturating counters so an oversize line/frame can never alias to a legal count
   assign col_d  = (&col_q)  ? col_q  : col_q + 10'd1;
   assign line_d = (&line_q) ? line_q : line_q + 9'd1;

   assign line_bad = phase_q | (col_q != WIDTH_C);
   assign wr_en    = pix_vld_q & (state_q == FRAME) & ~queue_full;
   assign drop     = pix_vld_q & (state_q == FRAME) & queue_full;
   assign pix_ok   = (col_q < WIDTH_C) & (line_q < HEIGHT_C);

   // Line-end check is folded in before the frame-end line count, so a
   // coincident h_ref fall and v_sync rise closes the line first.
   assign frame_bad = bad_q | drop | hr_q | (hr_fall & line_bad) |
                      ((hr_fall ? line_d : line_q) != HEIGHT_C);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= WAIT_VSYNC;
         col_q     <= '0;
         line_q    <= '0;
         phase_q   <= 1'b0;
         bad_q     <= 1'b0;
         arm_q     <= 1'b0;
         hi_q      <= '0;
         pix_vld_q <= 1'b0;
         fs_q      <= 1'b0;
         pix_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         pix_vld_q <= 1'b0;
         if (drop)  ovf_q <= 1'b1;
         if (wr_en) arm_q <= 1'b0;
         case (state_q)
            WAIT_VSYNC: begin
               if (vs_fall) begin
                  state_q <= FRAME;
                  col_q   <= '0;
                  line_q  <= '0;
                  phase_q <= 1'b0;
                  bad_q   <= 1'b0;
                  arm_q   <= 1'b1;
               end
            end
            FRAME: begin
               if (vs_rise) begin
                  done_q  <= 1'b1;
                  err_q   <= frame_bad;
                  state_q <= WAIT_VSYNC;
               end else if (drop) begin
                  bad_q   <= 1'b1;
                  state_q <= DROP;
               end else if (hr_fall) begin
                  if (line_bad) bad_q <= 1'b1;
                  line_q  <= line_d;
                  col_q   <= '0;
                  phase_q <= 1'b0;
               end else if (hr_q) begin
                  if (!phase_q) begin
                     hi_q    <= dat_q;
                     phase_q <= 1'b1;
                  end else begin
                     phase_q <= 1'b0;
                     col_q   <= col_d;
                     if (pix_ok) begin
                        pix_vld_q <= 1'b1;
                        pix_q     <= {hi_q, dat_q};
                        fs_q      <= arm_q;
                     end else begin
                        bad_q <= 1'b1;
                     end
                  end
               end
            end
            DROP: begin
               if (vs_rise) begin
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  state_q <= WAIT_VSYNC;
               end
            end
            default: state_q <= WAIT_VSYNC;
         endcase
      end
   end

   assign queue_data  = {fs_q, pix_q};
   assign queue_wr_en = wr_en;
   assign frame_done  = done_q;
   assign frame_error = err_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_cam_pixel_assembler.sv
// Scoreboard bench for cam_pixel_assembler: frame-level reference model feeds
// expected words/frame results into queues; a negedge monitor checks them.
module tb_cam_pixel_assembler;
   localparam int W = 4;
   localparam int H = 2;

   logic        clk = 1'b0;
   logic        reset_n, v_sync, h_ref, queue_full;
   logic [7:0]  cam_data;
   logic [16:0] queue_data;
   logic        queue_wr_en, frame_done, frame_error, overflow;

   always #5 clk = ~clk;

   cam_pixel_assembler #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
      .clk(clk), .reset_n(reset_n), .v_sync(v_sync), .h_ref(h_ref),
      .cam_data(cam_data), .queue_full(queue_full), .queue_data(queue_data),
      .queue_wr_en(queue_wr_en), .frame_done(frame_done),
      .frame_error(frame_error), .overflow(overflow)
   );

   int ntests = 0;
   int nfail  = 0;
   logic [16:0] wq[$];
   logic [1:0]  fq[$];

   bit full_pend, frm_first, frm_bad, dropped, ovf_m;
   int full_at, frm_written, line_idx;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor
   logic        wr_prev = 1'b0, done_prev = 1'b0;
   logic [16:0] mon_w;
   logic [1:0]  mon_f;
   always @(negedge clk) begin
      if (reset_n) begin
         if (queue_wr_en) begin
            chk("wr_spacing", 32'(wr_prev), 32'd0);
            if (wq.size() == 0) begin
               ntests++; nfail++;
               $display("FAIL unexpected_write: got 0x%0h expected none at %0t", queue_data, $time);
            end else begin
               mon_w = wq.pop_front();
               chk("write_data", 32'(queue_data), 32'(mon_w));
            end
         end
         if (frame_done) begin
            chk("done_width", 32'(done_prev), 32'd0);
            if (fq.size() == 0) begin
               ntests++; nfail++;
               $display("FAIL unexpected_frame_done: got err=%0b ovf=%0b expected none", frame_error, overflow);
            end else begin
               mon_f = fq.pop_front();
               chk("frame_err_ovf", 32'({frame_error, overflow}), 32'(mon_f));
            end
         end
      end
      wr_prev   = queue_wr_en & reset_n;
      done_prev = frame_done & reset_n;
   end

   task automatic step(input logic v, input logic h, input logic [7:0] d);
      if (full_pend) queue_full = 1'b1;
      v_sync = v; h_ref = h; cam_data = d;
      @(posedge clk); #1;
   endtask

   task automatic vs_pulse();
      full_pend  = 1'b0;
      queue_full = 1'b0;
      repeat (3) step(1'b1, 1'b0, 8'($urandom));
      repeat (3) step(1'b0, 1'b0, 8'($urandom));
   endtask

   task automatic frame_begin(input int fa);
      vs_pulse();
      line_idx = 0; frm_written = 0; frm_first = 1'b1;
      frm_bad = 1'b0; dropped = 1'b0; full_at = fa;
   endtask

   // Reference: pixel i of line l is written if l<H, i<W, and no drop yet
   task automatic send_line(input int n, input int gap, input bit fixed);
      logic [7:0] d, hi;
      int px;
      px = 0; hi = '0;
      for (int b = 0; b < n; b++) begin
         d = fixed ? 8'(18 + 34 * b) : 8'($urandom);
         step(1'b0, 1'b1, d);
         if (b % 2 == 0) hi = d;
         else begin
            if (!dropped && line_idx < H && px < W) begin
               if (frm_written == full_at) begin
                  dropped = 1'b1; full_pend = 1'b1; ovf_m = 1'b1; frm_bad = 1'b1;
               end else begin
                  wq.push_back({frm_first, hi, d});
                  frm_first = 1'b0;
                  frm_written++;
               end
            end
            px++;
         end
      end
      if ((n % 2) != 0 || (n / 2) != W) frm_bad = 1'b1;
      line_idx++;
      repeat (gap) step(1'b0, 1'b0, 8'($urandom));
   endtask

   task automatic send_frame(input int nl, input int lens[4], input int fa,
                             input bit tight, input bit fixed);
      frame_begin(fa);
      for (int i = 0; i < nl; i++)
         send_line(lens[i], (tight && i == nl - 1) ? 0 : 2, fixed);
      fq.push_back({frm_bad | (nl != H), ovf_m});
   endtask

   task automatic chk_reset_outputs();
      chk("rst_queue_data",  32'(queue_data),  32'd0);
      chk("rst_queue_wr_en", 32'(queue_wr_en), 32'd0);
      chk("rst_frame_done",  32'(frame_done),  32'd0);
      chk("rst_frame_error", 32'(frame_error), 32'd0);
      chk("rst_overflow",    32'(overflow),    32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nl, fa, lens[4];
      bit tight;
      logic [7:0] d, hi;
      reset_n = 1'b0; v_sync = 1'b0; h_ref = 1'b0; cam_data = '0; queue_full = 1'b0;
      full_pend = 1'b0; ovf_m = 1'b0; hi = '0;
      repeat (3) step(1'b0, 1'b0, 8'h00);
      chk_reset_outputs();
      reset_n = 1'b1;

      // Data before any v_sync fall must be ignored
      repeat (10) step(1'b0, 1'b1, 8'($urandom));
      step(1'b0, 1'b0, 8'h00);

      send_frame(2, '{8, 8, 0, 0}, -1, 1'b0, 1'b1);  // nominal, 0x12,0x34,...
      send_frame(2, '{8, 6, 0, 0}, -1, 1'b0, 1'b0);  // short line
      send_frame(2, '{8, 8, 0, 0}, -1, 1'b0, 1'b0);  // recovers
      send_frame(2, '{9, 8, 0, 0}, -1, 1'b0, 1'b0);  // odd byte count
      send_frame(2, '{8, 8, 0, 0},  2, 1'b0, 1'b0);  // backpressure on 3rd pixel
      send_frame(2, '{8, 8, 0, 0}, -1, 1'b0, 1'b0);  // normal, overflow sticky
      send_frame(2, '{8, 8, 0, 0}, -1, 1'b1, 1'b0);  // h_ref fall with v_sync rise
      send_frame(3, '{8, 8, 8, 0}, -1, 1'b0, 1'b0);  // too many lines
      send_frame(1, '{10, 0, 0, 0}, -1, 1'b0, 1'b0); // too few lines, long line

      for (int f = 0; f < 10; f++) begin
         nl = $urandom_range(1, 3);
         for (int i = 0; i < 4; i++)
            lens[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(6, 10)) : 8;
         fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
         tight = (fa < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         send_frame(nl, lens, fa, tight, 1'b0);
      end

      // Reset in the middle of a line after 3 written pixels
      frame_begin(-1);
      for (int b = 0; b < 8; b++) begin
         d = 8'($urandom);
         step(1'b0, 1'b1, d);
         if (b % 2 == 0) hi = d;
         else if (b < 6) begin
            wq.push_back({frm_first, hi, d});
            frm_first = 1'b0;
         end
      end
      reset_n = 1'b0;
      #1;
      chk_reset_outputs();
      repeat (3) step(1'b0, 1'b1, 8'($urandom));
      reset_n = 1'b1;
      ovf_m   = 1'b0;
      repeat (5) step(1'b0, 1'b1, 8'($urandom));
      step(1'b0, 1'b0, 8'h00);
      send_frame(2, '{8, 8, 0, 0}, -1, 1'b0, 1'b0);

      vs_pulse();
      repeat (10) step(1'b0, 1'b0, 8'h00);
      chk("writes_left", 32'(wq.size()), 32'd0);
      chk("frames_left", 32'(fq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
